// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with saturating direction counters and a sequenced invalidate.
// Optional BP_STATS_EN adds saturating lookup / mispredict statistics counters.
module bp_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_pc_f,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_pc,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            inv_req,
`ifdef BP_STATS_EN
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic            busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  logic             upd_v_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic [TAG_W-1:0] upd_tag_q;
  logic             upd_taken_q;
  logic [XLEN-1:0]  upd_target_q;

  // Fetch-side lookup
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;

  assign idx_f        = pc_f[IDX_W+1:2];
  assign tag_f        = pc_f[XLEN-1:IDX_W+2];
  assign busy         = (state == CLEAR);
  assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f) && !busy;
  assign pred_taken_f = hit_f && cnt_q[idx_f][CNT_W-1];
  assign pred_pc_f    = pred_taken_f ? target_q[idx_f] : pc_f + XLEN'(4);

  // Execute-side resolution check
  logic [XLEN-1:0] next_pc;

  assign next_pc     = upd_taken ? upd_target : upd_pc + XLEN'(4);
  assign redirect_pc = next_pc;
  assign mispredict  = upd_en && ((upd_taken != upd_pred_taken) || (next_pc != upd_pred_pc));

  // Invalidate sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: if (inv_req) begin
          state <= CLEAR;
          ptr   <= '0;
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Update stage; anything arriving during the sweep or with the invalidate request is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_v_q      <= 1'b0;
      upd_idx_q    <= '0;
      upd_tag_q    <= '0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= '0;
    end else begin
      upd_v_q      <= upd_en && (state == IDLE) && !inv_req;
      upd_idx_q    <= upd_pc[IDX_W+1:2];
      upd_tag_q    <= upd_pc[XLEN-1:IDX_W+2];
      upd_taken_q  <= upd_taken;
      upd_target_q <= upd_target;
    end
  end

  logic write_en;
  logic w_hit;

  assign write_en = upd_v_q && (state == IDLE);
  assign w_hit    = valid_q[upd_idx_q] && (tag_q[upd_idx_q] == upd_tag_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= '0;
    end else if (state == CLEAR) begin
      valid_q[ptr] <= 1'b0;
    end else if (write_en) begin
      if (w_hit) begin
        if (upd_taken_q) begin
          if (cnt_q[upd_idx_q] != CNT_MAX) cnt_q[upd_idx_q] <= cnt_q[upd_idx_q] + 1'b1;
        end else begin
          if (cnt_q[upd_idx_q] != '0) cnt_q[upd_idx_q] <= cnt_q[upd_idx_q] - 1'b1;
        end
      end else if (upd_taken_q) begin
        valid_q[upd_idx_q] <= 1'b1;
        cnt_q[upd_idx_q]   <= CNT_WEAK;
      end
    end
  end

  // NOTE: tag and target storage is not reset; valid_q gates every use, so it can map to plain RAM.
  always_ff @(posedge clk) begin
    if (write_en && upd_taken_q) begin
      tag_q[upd_idx_q]    <= upd_tag_q;
      target_q[upd_idx_q] <= upd_target_q;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (!busy && stat_lookups != '1) stat_lookups <= stat_lookups + 1'b1;
      if (mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_btb.sv
// Directed bench for bp_btb (ENTRIES=16, CNT_W=2): training, aliasing, invalidate sweep, reset mid-sweep.
module tb_bp_btb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        inv_req;
  logic        busy;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  bp_btb #(.XLEN(32), .ENTRIES(16), .CNT_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_f           (pc_f),
    .pred_taken_f   (pred_taken_f),
    .pred_pc_f      (pred_pc_f),
    .upd_en         (upd_en),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_pc    (upd_pred_pc),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .inv_req        (inv_req),
`ifdef BP_STATS_EN
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("check %s", tag);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic taken, input logic [31:0] npc);
    pc_f = pc;
    #1;
    check({tag, "_taken"}, {31'b0, pred_taken_f}, {31'b0, taken});
    check({tag, "_pc"}, pred_pc_f, npc);
  endtask

  // One-cycle update, then enough edges for the table write to land.
  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_en = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    tick();
    upd_en = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; pc_f = 32'h100; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_pc = '0; inv_req = 1'b0;
    #12;
    lookup("rst", 32'h100, 1'b0, 32'h104);
    check("rst_busy", {31'b0, busy}, 32'd0);
    lookup("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    reset = 1'b0;
    tick();

    // First taken resolve: mispredict and allocate weakly taken
    pc_f = 32'h100;
    upd_en = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
    upd_pred_taken = 1'b0; upd_pred_pc = 32'h104;
    #1;
    check("mp_alloc", {31'b0, mispredict}, 32'd1);
    check("redir_alloc", redirect_pc, 32'h200);
    tick();
    upd_en = 1'b0;
    lookup("edge1", 32'h100, 1'b0, 32'h104);
    tick();
    lookup("edge2", 32'h100, 1'b1, 32'h200);

    // Counter: 2 -> 3 -> 3 -> 2 -> 1 -> 0, then one taken gives 1 if the entry is still valid
    train(32'h100, 1'b1, 32'h200); lookup("c3a", 32'h100, 1'b1, 32'h200);
    train(32'h100, 1'b1, 32'h200); lookup("c3b", 32'h100, 1'b1, 32'h200);
    upd_pc = 32'h100; upd_taken = 1'b0; upd_pred_taken = 1'b1; upd_pred_pc = 32'h200; upd_en = 1'b1;
    #1;
    check("mp_nt", {31'b0, mispredict}, 32'd1);
    check("redir_nt", redirect_pc, 32'h104);
    upd_en = 1'b0;
    train(32'h100, 1'b0, 32'h0); lookup("c2", 32'h100, 1'b1, 32'h200);
    train(32'h100, 1'b0, 32'h0); lookup("c1", 32'h100, 1'b0, 32'h104);
    train(32'h100, 1'b0, 32'h0); lookup("c0", 32'h100, 1'b0, 32'h104);
    train(32'h100, 1'b0, 32'h0); lookup("c0sat", 32'h100, 1'b0, 32'h104);
    train(32'h100, 1'b1, 32'h200); lookup("c0inc", 32'h100, 1'b0, 32'h104);

    // Aliasing: 0x140 shares index 0 with 0x100 and evicts it
    upd_pc = 32'h140; upd_taken = 1'b1; upd_target = 32'h300;
    upd_pred_taken = 1'b1; upd_pred_pc = 32'h300; upd_en = 1'b1;
    #1;
    check("mp_correct", {31'b0, mispredict}, 32'd0);
    upd_en = 1'b0;
    train(32'h140, 1'b1, 32'h300);
    lookup("alias_old", 32'h100, 1'b0, 32'h104);
    lookup("alias_new", 32'h140, 1'b1, 32'h300);

    // Populate idx 1 and 2, then sweep
    train(32'h104, 1'b1, 32'h400);
    train(32'h108, 1'b1, 32'h500);
    lookup("pop1", 32'h104, 1'b1, 32'h400);
    lookup("pop2", 32'h108, 1'b1, 32'h500);
    inv_req = 1'b1;
    upd_en = 1'b1; upd_pc = 32'h10C; upd_taken = 1'b1; upd_target = 32'h700;
    tick();
    inv_req = 1'b0; upd_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sweep_busy%0d", i), {31'b0, busy}, 32'd1);
      if (i == 3) lookup("sweep_miss", 32'h108, 1'b0, 32'h10C);
      if (i == 6) begin
        upd_en = 1'b1; upd_pc = 32'h110; upd_taken = 1'b1; upd_target = 32'h800;
      end else begin
        upd_en = 1'b0;
      end
      inv_req = (i == 8);
      tick();
    end
    inv_req = 1'b0; upd_en = 1'b0;
    check("sweep_done", {31'b0, busy}, 32'd0);
    tick();
    lookup("post_140", 32'h140, 1'b0, 32'h144);
    lookup("post_104", 32'h104, 1'b0, 32'h108);
    lookup("post_108", 32'h108, 1'b0, 32'h10C);
    lookup("post_10c", 32'h10C, 1'b0, 32'h110);
    lookup("post_110", 32'h110, 1'b0, 32'h114);
    check("post_busy", {31'b0, busy}, 32'd0);

    // Reset during the sweep
    train(32'h104, 1'b1, 32'h400);
    lookup("repop", 32'h104, 1'b1, 32'h400);
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    lookup("rst_mid_miss", 32'h104, 1'b0, 32'h108);
    @(negedge clk);
    reset = 1'b0;
    tick();
    lookup("rst_after_miss", 32'h104, 1'b0, 32'h108);
    check("rst_after_busy", {31'b0, busy}, 32'd0);
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    begin
      int cycles;
      cycles = 0;
      while (busy && cycles < 40) begin
        tick();
        cycles++;
      end
      check("reinv_len", cycles, 32'd16);
    end
    check("reinv_done", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_btb.md
Name: bp_btb

Overview:
- Parametrised direct-mapped branch target buffer with a saturating-counter direction predictor for the fetch stage of the RISC-V pipeline.
- Predicts next fetch PC from pc_f in the same cycle.
- Trained by resolved branches from the execute stage.
- Reports mispredicts and redirect PC to drive the fetch/decode flush logic.
- Supports a sequenced whole-table invalidate.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, table entries; power of two, >=2; IDX_W = log2(ENTRIES)
CNT_W, 2, direction counter width (1..4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
pc_f  in  XLEN  fetch PC (word aligned)
pred_taken_f  out  1  predicted taken for pc_f
pred_pc_f  out  XLEN  predicted next fetch PC
upd_en  in  1  resolved control-flow instruction valid in execute
upd_pc  in  XLEN  PC of resolved instruction
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual taken target
upd_pred_taken  in  1  prediction made at fetch, carried down the pipe
upd_pred_pc  in  XLEN  predicted next PC, carried down the pipe
mispredict  out  1  resolved instruction was mispredicted
redirect_pc  out  XLEN  correct next PC on mispredict
inv_req  in  1  pulse: invalidate entire table
busy  out  1  invalidate sweep in progress

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Entry fields: valid, tag, target (XLEN), counter (CNT_W).
- Lookup is combinational on pc_f.
  - hit = valid[idx] & tag match & !busy.
  - pred_taken_f = hit & counter MSB.
  - pred_pc_f = pred_taken_f ? target : pc_f+4 (mod 2^XLEN).
- Mispredict is combinational, from upd_* inputs.
  - Correct next PC = upd_taken ? upd_target : upd_pc+4.
  - mispredict = upd_en & (upd_taken != upd_pred_taken | correct next PC != upd_pred_pc).
  - redirect_pc = correct next PC. Value is don't-care when mispredict = 0 but must be deterministic.
- Training: upd_* is registered into an update stage (latency 1). The table write occurs on the following clock edge, so the new state is visible to lookups 2 edges after upd_en.
  - Hit, taken: counter saturating increment (max 2^CNT_W-1); target <= upd_target.
  - Hit, not taken: counter saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate, overwriting any occupant. valid=1, tag, target, counter = 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- Simultaneous lookup and write to the same index in one cycle: lookup returns pre-write contents (no bypass).
- Invalidate FSM, states IDLE and CLEAR.
  - IDLE: inv_req=1 -> CLEAR, ptr <= 0.
  - CLEAR: clears valid[ptr] each cycle, ptr increments. After clearing index ENTRIES-1 -> IDLE.
  - busy = 1 exactly in CLEAR, i.e. ENTRIES cycles.
  - inv_req while CLEAR is ignored.
  - During CLEAR, lookups miss and pending/new updates are dropped. mispredict/redirect_pc still operate.
  - An update registered in the cycle inv_req is sampled is dropped.
- Reset (async, any time, including mid-sweep):
  - all valid = 0, counters = 0, FSM = IDLE, ptr = 0, update stage empty.
  - Outputs: pred_taken_f = 0, pred_pc_f = pc_f+4, busy = 0. mispredict follows the upd_* inputs only.
- Counters never wrap. Index aliasing (same index, different tag) is resolved by tag compare; the new allocation evicts.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, add outputs stat_lookups (32 bits) and stat_mispredicts (32 bits):
  - stat_lookups increments every cycle !busy.
  - stat_mispredicts increments on each mispredict.
  - Both saturate at 2^32-1 and reset to 0.
- When undefined, the ports and counters are absent and other behaviour is identical.

Test Plan:
All scenarios use ENTRIES=16, CNT_W=2.
- Reset then pc_f=0x100 -> pred_taken_f=0, pred_pc_f=0x104, busy=0.
- upd_en, upd_pc=0x100, taken, target=0x200, pred_taken=0, pred_pc=0x104 -> mispredict=1, redirect_pc=0x200. Two edges later, pc_f=0x100 gives pred_taken_f=1, pred_pc_f=0x200 (counter=2).
- Train 0x100 taken 2 more times, then not-taken 3 times -> counter 3,3,2,1,0. pred_taken_f=0 after the 2nd not-taken write. Entry stays valid.
- Allocate 0x100, then taken at 0x140 (same index, different tag):
  - 0x100 misses (pred_pc_f=0x104).
  - 0x140 hits.
  - mispredict=0 when upd_pred_pc equals the actual next PC.
- Populate 3 entries, pulse inv_req:
  - busy=1 for exactly 16 cycles.
  - All lookups miss.
  - An update during the sweep is dropped.
  - Entries are empty afterwards.
- Assert reset at sweep cycle 5 -> busy=0 immediately. Table empty. A new inv_req is accepted normally.
